// File: rtl/dpe_vector_feeder_pkg.sv
// Shared constants, types and the feeder state encoding for the dot-product engine front end.
// The engine latency follows from its adder-tree depth, so both are derived from LANES here.
package dpe_pkg;

   localparam int LANES        = 16;
   localparam int IPREC        = 8;
   localparam int DATAW        = LANES * IPREC;
   localparam int ADDER_STAGES = $clog2(LANES);
   localparam int DPE_LAT      = 2 + ADDER_STAGES;
   localparam int ADDRW        = 10;
   localparam int LENW         = 16;

   // The drain counter also spans the o_done cycle, so the FSM leaves DRAIN one cycle after the pulse.
   localparam int DRAIN_LOAD   = DPE_LAT + 1;
   localparam int DRAINW       = $clog2(DRAIN_LOAD + 1);

   typedef logic [ADDRW-1:0] addr_t;
   typedef logic [LENW-1:0]  len_t;
   typedef logic [DATAW-1:0] chunk_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } feed_state_e;

   function automatic addr_t addr_inc(input addr_t a);
      return a + addr_t'(1);
   endfunction

endpackage

// File: rtl/dpe_vector_feeder_if.sv
// Command, buffer-read and engine-beat signals of the vector feeder.
// master is the feeder side; slave is the surrounding buffers, command source and engine.
interface dpe_vector_feeder_if
   import dpe_pkg::*;
();

   logic   cmd_valid;
   logic   cmd_ready;
   addr_t  cmd_addr_a;
   addr_t  cmd_addr_b;
   len_t   cmd_len;
   logic   i_pause;

   logic   rd_en;
   addr_t  rd_addr_a;
   addr_t  rd_addr_b;
   chunk_t rd_data_a;
   chunk_t rd_data_b;

   logic   o_valid;
   chunk_t o_dataa;
   chunk_t o_datab;
   logic   o_last;
   logic   o_busy;
   logic   o_done;

   modport master (
      input  cmd_valid, cmd_addr_a, cmd_addr_b, cmd_len, i_pause,
      input  rd_data_a, rd_data_b,
      output cmd_ready, rd_en, rd_addr_a, rd_addr_b,
      output o_valid, o_dataa, o_datab, o_last, o_busy, o_done
   );

   modport slave (
      output cmd_valid, cmd_addr_a, cmd_addr_b, cmd_len, i_pause,
      output rd_data_a, rd_data_b,
      input  cmd_ready, rd_en, rd_addr_a, rd_addr_b,
      input  o_valid, o_dataa, o_datab, o_last, o_busy, o_done
   );

endinterface

// File: rtl/dpe_feed_addr_gen.sv
// Paired read-address walker: loads two base addresses and a chunk count, steps both on each issue.
// last_issue flags that the current addresses are the final pair of the command.
module dpe_feed_addr_gen
   import dpe_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  load,
   input  addr_t load_addr_a,
   input  addr_t load_addr_b,
   input  len_t  load_len,
   input  logic  advance,
   output addr_t addr_a,
   output addr_t addr_b,
   output logic  last_issue
);

   addr_t addr_a_reg, addr_a_next;
   addr_t addr_b_reg, addr_b_next;
   len_t  remaining_reg, remaining_next;

   always_comb begin
      addr_a_next    = addr_a_reg;
      addr_b_next    = addr_b_reg;
      remaining_next = remaining_reg;
      if (load) begin
         addr_a_next    = load_addr_a;
         addr_b_next    = load_addr_b;
         remaining_next = load_len;
      end else if (advance) begin
         // Addresses wrap naturally at the top of the buffer.
         addr_a_next    = addr_inc(addr_a_reg);
         addr_b_next    = addr_inc(addr_b_reg);
         remaining_next = remaining_reg - len_t'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_a_reg    <= '0;
         addr_b_reg    <= '0;
         remaining_reg <= '0;
      end else begin
         addr_a_reg    <= addr_a_next;
         addr_b_reg    <= addr_b_next;
         remaining_reg <= remaining_next;
      end
   end

   assign addr_a     = addr_a_reg;
   assign addr_b     = addr_b_reg;
   assign last_issue = (remaining_reg == len_t'(1));

endmodule

// File: rtl/dpe_vector_feeder.sv
// Reads paired chunks from the A/B vector buffers and streams them to the dot-product engine,
// then waits out the engine pipeline before signalling completion.
module dpe_vector_feeder
   import dpe_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   dpe_vector_feeder_if.master bus
);

   feed_state_e       state_reg, state_next;
   logic [DRAINW-1:0] drain_cnt_reg, drain_cnt_next;
   logic              done_reg, done_next;

   logic  gen_load;
   logic  rd_fire;
   logic  last_issue;
   addr_t gen_addr_a;
   addr_t gen_addr_b;

   logic   pipe_valid_reg;
   logic   pipe_last_reg;
   logic   out_valid_reg;
   logic   out_last_reg;
   chunk_t out_a_bus;
   chunk_t out_b_bus;

   dpe_feed_addr_gen u_addr_gen (
      .clk         (clk),
      .rst         (rst),
      .load        (gen_load),
      .load_addr_a (bus.cmd_addr_a),
      .load_addr_b (bus.cmd_addr_b),
      .load_len    (bus.cmd_len),
      .advance     (rd_fire),
      .addr_a      (gen_addr_a),
      .addr_b      (gen_addr_b),
      .last_issue  (last_issue)
   );

   assign rd_fire = (state_reg == ISSUE) && !bus.i_pause;

   always_comb begin
      state_next     = state_reg;
      drain_cnt_next = drain_cnt_reg;
      done_next      = 1'b0;
      gen_load       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.cmd_valid) begin
               gen_load = 1'b1;
               if (bus.cmd_len == '0) begin
                  done_next = 1'b1;
               end else begin
                  state_next = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (rd_fire && last_issue) begin
               state_next     = DRAIN;
               drain_cnt_next = DRAINW'(DRAIN_LOAD);
            end
         end
         DRAIN: begin
            // Count 1 lands the pulse DPE_LAT cycles after the o_last beat; count 0 is the pulse cycle.
            if (drain_cnt_reg != '0) begin
               drain_cnt_next = drain_cnt_reg - DRAINW'(1);
            end
            if (drain_cnt_reg == DRAINW'(1)) begin
               done_next = 1'b1;
            end
            if (drain_cnt_reg == '0) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         drain_cnt_reg <= '0;
         done_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         drain_cnt_reg <= drain_cnt_next;
         done_reg      <= done_next;
      end
   end

   // Beat qualifiers follow the buffer latency: one stage for the read, one for the output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_valid_reg <= 1'b0;
         pipe_last_reg  <= 1'b0;
         out_valid_reg  <= 1'b0;
         out_last_reg   <= 1'b0;
      end else begin
         pipe_valid_reg <= rd_fire;
         pipe_last_reg  <= rd_fire && last_issue;
         out_valid_reg  <= pipe_valid_reg;
         out_last_reg   <= pipe_last_reg;
      end
   end

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [IPREC-1:0] lane_a_reg;
      logic [IPREC-1:0] lane_b_reg;

      always_ff @(posedge clk) begin
         if (rst) begin
            lane_a_reg <= '0;
            lane_b_reg <= '0;
         end else if (pipe_valid_reg) begin
            lane_a_reg <= bus.rd_data_a[gi*IPREC +: IPREC];
            lane_b_reg <= bus.rd_data_b[gi*IPREC +: IPREC];
         end
      end

      assign out_a_bus[gi*IPREC +: IPREC] = lane_a_reg;
      assign out_b_bus[gi*IPREC +: IPREC] = lane_b_reg;
   end

   assign bus.cmd_ready = (state_reg == IDLE);
   assign bus.rd_en     = rd_fire;
   assign bus.rd_addr_a = gen_addr_a;
   assign bus.rd_addr_b = gen_addr_b;
   assign bus.o_valid   = out_valid_reg;
   assign bus.o_dataa   = out_a_bus;
   assign bus.o_datab   = out_b_bus;
   assign bus.o_last    = out_last_reg;
   assign bus.o_busy    = (state_reg != IDLE);
   assign bus.o_done    = done_reg;

endmodule

// File: tb/tb_dpe_vector_feeder.sv
// Randomised self-checking bench for dpe_vector_feeder with behavioural buffers and engine.
module tb_dpe_vector_feeder;
   import dpe_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   dpe_vector_feeder_if bus ();

   dpe_vector_feeder u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct { int c; addr_t a; addr_t b; } rd_t;
   typedef struct { int c; chunk_t da; chunk_t db; logic last; } beat_t;
   typedef struct { int c; int d; } res_t;

   chunk_t mem_a [1024];
   chunk_t mem_b [1024];
   rd_t    rd_q [$];
   beat_t  beat_q [$];
   res_t   res_q [$];
   int     done_q [$];
   int     exp_rd [$];
   int     cyc = 0;
   int     ready_low = 0;
   int     stray_last = 0;
   int     n_cmp = 0;
   int     n_err = 0;

   function automatic int dot(input chunk_t x, input chunk_t y);
      int s = 0;
      for (int l = 0; l < LANES; l++)
         s += int'($signed(x[l*IPREC +: IPREC])) * int'($signed(y[l*IPREC +: IPREC]));
      return s;
   endfunction

   // Synchronous-read buffers with one cycle of latency.
   always @(posedge clk) begin
      if (bus.rd_en) begin
         bus.rd_data_a <= mem_a[bus.rd_addr_a];
         bus.rd_data_b <= mem_b[bus.rd_addr_b];
      end
   end

   // Engine model: a dot product per beat, delivered DPE_LAT cycles later.
   logic [DPE_LAT-1:0] eng_v = '0;
   int eng_d [DPE_LAT];
   always @(posedge clk) begin
      eng_v    <= {eng_v[DPE_LAT-2:0], bus.o_valid};
      eng_d[0] <= dot(bus.o_dataa, bus.o_datab);
      for (int i = 1; i < DPE_LAT; i++) eng_d[i] <= eng_d[i-1];
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (bus.rd_en) rd_q.push_back('{cyc, bus.rd_addr_a, bus.rd_addr_b});
      if (bus.o_valid) beat_q.push_back('{cyc, bus.o_dataa, bus.o_datab, bus.o_last});
      if (bus.o_last && !bus.o_valid) stray_last++;
      if (bus.o_done) done_q.push_back(cyc);
      if (!bus.cmd_ready) ready_low++;
      if (eng_v[DPE_LAT-1]) res_q.push_back('{cyc, eng_d[DPE_LAT-1]});
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic clear_logs;
      rd_q.delete(); beat_q.delete(); res_q.delete(); done_q.delete();
      ready_low = 0; stray_last = 0;
   endtask

   // Offers one command, applies pause mask bit k during cycle T+k, waits for o_done.
   task automatic run_cmd(input addr_t a, input addr_t b, input len_t len,
                          input logic [63:0] pm, output int t_hs, output bit to);
      logic [5:0] k6;
      clear_logs();
      t_hs = -1;
      to   = 1'b0;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b1; bus.cmd_addr_a = a; bus.cmd_addr_b = b; bus.cmd_len = len;
      for (int w = 0; w < 50 && t_hs < 0; w++) begin
         @(negedge clk);
         if (bus.cmd_ready) t_hs = cyc;
      end
      for (int k = 1; k < int'(len) + 200; k++) begin
         @(posedge clk); #1;
         bus.cmd_valid = 1'b0;
         k6 = 6'(k);
         bus.i_pause = (k < 64) ? pm[k6] : 1'b0;
         if (done_q.size() > 0) break;
      end
      bus.i_pause = 1'b0;
      if (t_hs < 0 || done_q.size() == 0) to = 1'b1;
      repeat (10) @(posedge clk);
   endtask

   // Reads go to the first non-paused cycles after the handshake, one chunk pair each.
   task automatic model_cmd(input int t_hs, input int len, input logic [63:0] pm);
      int c;
      logic [5:0] k6;
      exp_rd.delete();
      c = t_hs + 1;
      for (int i = 0; i < len; i++) begin
         forever begin
            k6 = 6'(c - t_hs);
            if ((c - t_hs) < 64 && pm[k6]) c++;
            else break;
         end
         exp_rd.push_back(c);
         c++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready); end
      n_cmp++; if (bus.rd_en !== 1'b0) begin n_err++; $display("FAIL reset_rd_en: got %b want 0", bus.rd_en); end
      n_cmp++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL reset_o_valid: got %b want 0", bus.o_valid); end
      n_cmp++; if (bus.o_last !== 1'b0) begin n_err++; $display("FAIL reset_o_last: got %b want 0", bus.o_last); end
      n_cmp++; if (bus.o_busy !== 1'b0) begin n_err++; $display("FAIL reset_o_busy: got %b want 0", bus.o_busy); end
      n_cmp++; if (bus.o_done !== 1'b0) begin n_err++; $display("FAIL reset_o_done: got %b want 0", bus.o_done); end
      n_cmp++; if (bus.o_dataa !== '0) begin n_err++; $display("FAIL reset_o_dataa: got %h want 0", bus.o_dataa); end
      @(posedge clk); #1;
      rst = 1'b0;
      $display("test_reset: done");
   endtask

   task automatic test_basic;
      int t; bit to;
      run_cmd(10'h000, 10'h100, 16'd4, 64'd0, t, to);
      n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL basic_timeout: got %0d want 0", to); end
      n_cmp++; if (rd_q.size() !== 4) begin n_err++; $display("FAIL basic_rd_count: got %0d want 4", rd_q.size()); end
      for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
         n_cmp++;
         if (rd_q[i].c !== t + 1 + i || rd_q[i].a !== addr_t'(i) || rd_q[i].b !== addr_t'(256 + i)) begin
            n_err++; $display("FAIL basic_rd[%0d]: got c=%0d a=%h b=%h want c=%0d a=%h b=%h",
                              i, rd_q[i].c, rd_q[i].a, rd_q[i].b, t + 1 + i, i, 256 + i);
         end
      end
      n_cmp++; if (beat_q.size() !== 4) begin n_err++; $display("FAIL basic_beat_count: got %0d want 4", beat_q.size()); end
      for (int i = 0; i < 4 && i < beat_q.size(); i++) begin
         n_cmp++;
         if (beat_q[i].c !== t + 3 + i || beat_q[i].da !== mem_a[i] || beat_q[i].db !== mem_b[256 + i]
             || beat_q[i].last !== (i == 3)) begin
            n_err++; $display("FAIL basic_beat[%0d]: got c=%0d last=%b want c=%0d last=%b (data %s)",
                              i, beat_q[i].c, beat_q[i].last, t + 3 + i, i == 3,
                              (beat_q[i].da === mem_a[i]) ? "ok" : "wrong");
         end
      end
      n_cmp++; if (done_q.size() !== 1) begin n_err++; $display("FAIL basic_done_count: got %0d want 1", done_q.size()); end
      else begin
         n_cmp++; if (done_q[0] !== t + 12) begin n_err++; $display("FAIL basic_done_cycle: got %0d want %0d", done_q[0], t + 12); end
      end
      $display("test_basic: T=%0d reads=%0d beats=%0d", t, rd_q.size(), beat_q.size());
   endtask

   task automatic test_pause;
      int t; bit to; addr_t a, b; int ec;
      a = addr_t'($urandom); b = addr_t'($urandom);
      run_cmd(a, b, 16'd8, 64'h38, t, to);
      n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL pause_timeout: got %0d want 0", to); end
      n_cmp++; if (beat_q.size() !== 8) begin n_err++; $display("FAIL pause_beat_count: got %0d want 8", beat_q.size()); end
      for (int i = 0; i < 8 && i < beat_q.size(); i++) begin
         ec = (i < 2) ? t + 3 + i : t + 6 + i;
         n_cmp++;
         if (beat_q[i].c !== ec || beat_q[i].da !== mem_a[addr_t'(a + i)] || beat_q[i].db !== mem_b[addr_t'(b + i)]
             || beat_q[i].last !== (i == 7)) begin
            n_err++; $display("FAIL pause_beat[%0d]: got c=%0d last=%b want c=%0d last=%b", i, beat_q[i].c, beat_q[i].last, ec, i == 7);
         end
      end
      n_cmp++; if (done_q.size() !== 1) begin n_err++; $display("FAIL pause_done_count: got %0d want 1", done_q.size()); end
      else begin
         n_cmp++; if (done_q[0] !== t + 13 + DPE_LAT) begin n_err++; $display("FAIL pause_done_cycle: got %0d want %0d", done_q[0], t + 13 + DPE_LAT); end
      end
      $display("test_pause: T=%0d beats=%0d", t, beat_q.size());
   endtask

   task automatic test_zero_len;
      int t; bit to;
      run_cmd(addr_t'($urandom), addr_t'($urandom), 16'd0, 64'd0, t, to);
      n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL zero_timeout: got %0d want 0", to); end
      n_cmp++; if (rd_q.size() !== 0 || beat_q.size() !== 0) begin n_err++; $display("FAIL zero_activity: got rd=%0d beats=%0d want 0/0", rd_q.size(), beat_q.size()); end
      n_cmp++; if (done_q.size() !== 1 || done_q[0] !== t + 1) begin n_err++; $display("FAIL zero_done: got count=%0d want one pulse at %0d", done_q.size(), t + 1); end
      n_cmp++; if (ready_low !== 0) begin n_err++; $display("FAIL zero_cmd_ready: got %0d low cycles want 0", ready_low); end
      $display("test_zero_len: T=%0d done_pulses=%0d", t, done_q.size());
   endtask

   task automatic test_addr_wrap;
      int t; bit to; addr_t b;
      addr_t exp_a [4];
      exp_a[0] = 10'h3FE; exp_a[1] = 10'h3FF; exp_a[2] = 10'h000; exp_a[3] = 10'h001;
      b = addr_t'($urandom);
      run_cmd(10'h3FE, b, 16'd4, 64'd0, t, to);
      n_cmp++; if (to !== 1'b0 || rd_q.size() !== 4) begin n_err++; $display("FAIL wrap_rd_count: got %0d want 4 (timeout=%0d)", rd_q.size(), to); end
      for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
         n_cmp++; if (rd_q[i].a !== exp_a[i]) begin n_err++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, rd_q[i].a, exp_a[i]); end
      end
      for (int i = 0; i < 4 && i < beat_q.size(); i++) begin
         n_cmp++; if (beat_q[i].da !== mem_a[exp_a[i]]) begin n_err++; $display("FAIL wrap_data[%0d]: got %h want %h", i, beat_q[i].da, mem_a[exp_a[i]]); end
      end
      $display("test_addr_wrap: T=%0d reads=%0d", t, rd_q.size());
   endtask

   task automatic test_reset_mid_op;
      int t; bit to;
      clear_logs();
      t = -1;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b1; bus.cmd_addr_a = 10'h010; bus.cmd_addr_b = 10'h020; bus.cmd_len = 16'd8;
      @(negedge clk);
      t = cyc;
      @(posedge clk); #1; bus.cmd_valid = 1'b0;
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL midrst_cmd_ready: got %b want 1", bus.cmd_ready); end
      repeat (20) @(posedge clk);
      n_cmp++; if (beat_q.size() !== 0) begin n_err++; $display("FAIL midrst_beats: got %0d want 0", beat_q.size()); end
      n_cmp++; if (done_q.size() !== 0) begin n_err++; $display("FAIL midrst_done: got %0d want 0", done_q.size()); end
      run_cmd(10'h040, 10'h050, 16'd3, 64'd0, t, to);
      n_cmp++; if (to !== 1'b0 || beat_q.size() !== 3) begin n_err++; $display("FAIL midrst_followup: got %0d beats want 3 (timeout=%0d)", beat_q.size(), to); end
      else begin
         n_cmp++; if (beat_q[0].da !== mem_a[10'h040] || beat_q[2].db !== mem_b[10'h052]) begin n_err++; $display("FAIL midrst_followup_data: got %h want %h", beat_q[0].da, mem_a[10'h040]); end
      end
      $display("test_reset_mid_op: followup T=%0d beats=%0d", t, beat_q.size());
   endtask

   task automatic test_random;
      int t; bit to; addr_t a, b; int len; logic [63:0] pm;
      for (int n = 0; n < 8; n++) begin
         a = addr_t'($urandom); b = addr_t'($urandom); len = $urandom_range(1, 24);
         pm = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
         run_cmd(a, b, len_t'(len), pm, t, to);
         model_cmd(t, len, pm);
         n_cmp++; if (to !== 1'b0 || rd_q.size() !== len) begin n_err++; $display("FAIL rand%0d_rd_count: got %0d want %0d (timeout=%0d)", n, rd_q.size(), len, to); end
         for (int i = 0; i < len && i < rd_q.size(); i++) begin
            n_cmp++;
            if (rd_q[i].c !== exp_rd[i] || rd_q[i].a !== addr_t'(a + i) || rd_q[i].b !== addr_t'(b + i)) begin
               n_err++; $display("FAIL rand%0d_rd[%0d]: got c=%0d a=%h want c=%0d a=%h", n, i, rd_q[i].c, rd_q[i].a, exp_rd[i], addr_t'(a + i));
            end
         end
         n_cmp++; if (beat_q.size() !== len) begin n_err++; $display("FAIL rand%0d_beat_count: got %0d want %0d", n, beat_q.size(), len); end
         for (int i = 0; i < len && i < beat_q.size(); i++) begin
            n_cmp++;
            if (beat_q[i].c !== exp_rd[i] + 2 || beat_q[i].da !== mem_a[addr_t'(a + i)]
                || beat_q[i].db !== mem_b[addr_t'(b + i)] || beat_q[i].last !== (i == len - 1)) begin
               n_err++; $display("FAIL rand%0d_beat[%0d]: got c=%0d last=%b want c=%0d last=%b", n, i, beat_q[i].c, beat_q[i].last, exp_rd[i] + 2, i == len - 1);
            end
         end
         n_cmp++;
         if (done_q.size() !== 1 || stray_last !== 0) begin
            n_err++; $display("FAIL rand%0d_done_count: got %0d pulses, %0d stray o_last want 1/0", n, done_q.size(), stray_last);
         end else begin
            n_cmp++; if (done_q[0] !== exp_rd[len-1] + 2 + DPE_LAT) begin n_err++; $display("FAIL rand%0d_done_cycle: got %0d want %0d", n, done_q[0], exp_rd[len-1] + 2 + DPE_LAT); end
         end
         $display("test_random[%0d]: a=%h b=%h len=%0d T=%0d beats=%0d", n, a, b, len, t, beat_q.size());
      end
   endtask

   task automatic test_back_to_back;
      int t1, t2; addr_t a1, b1, a2, b2; int len1, len2, tot, ref_d;
      addr_t ea, eb;
      a1 = addr_t'($urandom); b1 = addr_t'($urandom); len1 = $urandom_range(3, 10);
      a2 = addr_t'($urandom); b2 = addr_t'($urandom); len2 = $urandom_range(3, 10);
      tot = len1 + len2;
      clear_logs();
      t1 = -1; t2 = -1;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b1; bus.cmd_addr_a = a1; bus.cmd_addr_b = b1; bus.cmd_len = len_t'(len1);
      for (int w = 0; w < 50 && t1 < 0; w++) begin @(negedge clk); if (bus.cmd_ready) t1 = cyc; end
      @(posedge clk); #1;
      bus.cmd_addr_a = a2; bus.cmd_addr_b = b2; bus.cmd_len = len_t'(len2);
      for (int w = 0; w < 200 && t2 < 0; w++) begin @(negedge clk); if (bus.cmd_ready) t2 = cyc; end
      @(posedge clk); #1; bus.cmd_valid = 1'b0;
      for (int w = 0; w < 200 && done_q.size() < 2; w++) @(posedge clk);
      repeat (10) @(posedge clk);
      n_cmp++; if (t1 < 0 || t2 < 0 || done_q.size() !== 2) begin n_err++; $display("FAIL b2b_progress: got t1=%0d t2=%0d done=%0d want 2 accepted, 2 done", t1, t2, done_q.size()); end
      else begin
         n_cmp++; if (t2 !== done_q[0] + 1) begin n_err++; $display("FAIL b2b_accept_cycle: got %0d want %0d", t2, done_q[0] + 1); end
      end
      n_cmp++; if (res_q.size() !== tot || beat_q.size() !== tot) begin n_err++; $display("FAIL b2b_result_count: got %0d results %0d beats want %0d", res_q.size(), beat_q.size(), tot); end
      for (int i = 0; i < tot && i < res_q.size() && i < beat_q.size(); i++) begin
         ea = (i < len1) ? addr_t'(a1 + i) : addr_t'(a2 + i - len1);
         eb = (i < len1) ? addr_t'(b1 + i) : addr_t'(b2 + i - len1);
         ref_d = dot(mem_a[ea], mem_b[eb]);
         n_cmp++;
         if (res_q[i].d !== ref_d || res_q[i].c !== beat_q[i].c + DPE_LAT) begin
            n_err++; $display("FAIL b2b_result[%0d]: got d=%0d c=%0d want d=%0d c=%0d", i, res_q[i].d, res_q[i].c, ref_d, beat_q[i].c + DPE_LAT);
         end
      end
      if (done_q.size() == 2 && res_q.size() == tot && tot > len1) begin
         n_cmp++;
         if (done_q[0] !== res_q[len1-1].c || done_q[1] !== res_q[tot-1].c) begin
            n_err++; $display("FAIL b2b_done_vs_result: got %0d,%0d want %0d,%0d", done_q[0], done_q[1], res_q[len1-1].c, res_q[tot-1].c);
         end
      end
      $display("test_back_to_back: len1=%0d len2=%0d t1=%0d t2=%0d results=%0d", len1, len2, t1, t2, res_q.size());
   endtask

   initial begin
      bus.cmd_valid  = 1'b0;
      bus.cmd_addr_a = '0;
      bus.cmd_addr_b = '0;
      bus.cmd_len    = '0;
      bus.i_pause    = 1'b0;
      bus.rd_data_a  = '0;
      bus.rd_data_b  = '0;
      for (int i = 0; i < 1024; i++) begin
         mem_a[i] = {$urandom, $urandom, $urandom, $urandom};
         mem_b[i] = {$urandom, $urandom, $urandom, $urandom};
      end
      test_reset();
      test_basic();
      test_pause();
      test_zero_len();
      test_addr_wrap();
      test_reset_mid_op();
      test_random();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dpe_vector_feeder.md
Name: dpe_vector_feeder

Overview:
- Transmit side of the dot-product engine input interface. Drives the engine's i_valid, i_dataa and i_datab ports.
- Accepts a command (two base addresses and a length in chunks) and reads paired LANES-wide chunks from two synchronous-read vector buffers (1-cycle read latency).
- Issues each chunk pair to the engine as one valid beat, marks the last beat, and pulses done once the last result has left the engine pipeline.

Parameters:
- LANES, 16, elements per chunk
- IPREC, 8, bits per element
- DATAW, LANES*IPREC, chunk width in bits
- ADDRW, 10, buffer address width
- LENW, 16, command length width (chunks)
- DPE_LAT, 6, engine input-to-output latency in cycles (2 + log2(LANES))

Ports:
- clk, input, 1, clock
- rst, input, 1, synchronous active-high reset
- cmd_valid, input, 1, command offered
- cmd_ready, output, 1, command accepted when high with cmd_valid
- cmd_addr_a, input, ADDRW, base address of vector A
- cmd_addr_b, input, ADDRW, base address of vector B
- cmd_len, input, LENW, number of chunk pairs
- i_pause, input, 1, stop issuing new reads while high
- rd_en, output, 1, read strobe shared by both buffers
- rd_addr_a, output, ADDRW, buffer A address
- rd_addr_b, output, ADDRW, buffer B address
- rd_data_a, input, DATAW, buffer A data, valid 1 cycle after rd_en
- rd_data_b, input, DATAW, buffer B data, valid 1 cycle after rd_en
- o_valid, output, 1, to engine i_valid
- o_dataa, output, DATAW, to engine i_dataa
- o_datab, output, DATAW, to engine i_datab
- o_last, output, 1, high with o_valid on the final chunk of a command
- o_busy, output, 1, high whenever the FSM is not in IDLE
- o_done, output, 1, single-cycle pulse when the command completes

Behaviour:
- Reset values: all outputs 0 except cmd_ready=1. FSM goes to IDLE. Counters and the pipeline valid register clear.
- Reset mid-operation: in-flight read data is discarded and no o_valid appears afterwards.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - cmd_ready=1. On handshake in cycle T, latch the addresses and the length.
  - If cmd_len=0: o_done pulses in T+1, and the FSM stays in IDLE (cmd_ready stays 1).
  - Otherwise go to ISSUE.
- ISSUE:
  - cmd_ready=0.
  - Each cycle with i_pause=0: rd_en=1, issue the current addresses, then both addresses +1 (modulo 2^ADDRW) and remaining count −1.
  - With i_pause=1: rd_en=0 and the addresses hold.
  - After the issue with remaining=1, go to DRAIN.
- Data path timing:
  - rd_en at cycle t → rd_data sampled at the end of t+1 → o_valid, o_dataa, o_datab registered and visible in t+2.
  - o_last travels with the beat.
  - When no beat is present: o_valid=0, and o_dataa/o_datab hold their last values (no zeroing required).
- Pause:
  - A read already issued before i_pause rises still produces its o_valid beat.
  - Pausing never drops or duplicates a beat.
  - The engine has no backpressure, so beats leave unconditionally.
- DRAIN:
  - Counter loaded so that o_done pulses exactly DPE_LAT cycles after the o_last beat; the FSM then returns to IDLE.
  - i_pause is ignored in DRAIN.
- Minimum command-to-command spacing: a new cmd_valid in the o_done cycle sees cmd_ready=0. It is accepted in the next cycle (IDLE).
- Widths:
  - cmd_len up to 2^LENW−1.
  - Address wrap at 2^ADDRW−1 → 0 is legal and silent.

Decomposition:
- Shared package dpe_pkg holds:
  - constants LANES, IPREC, DATAW, ADDER_STAGES, and DPE_LAT = 2 + ADDER_STAGES;
  - the state enum {IDLE, ISSUE, DRAIN}.
- One sub-module, dpe_feed_addr_gen: address/length counter with pause and a last-issue flag.
- The FSM, data registers and drain counter stay in the top module.

Test Plan:
- Basic command:
  - Stimulus: reset; cmd_addr_a=0, cmd_addr_b=0x100, cmd_len=4, handshake at T, buffers preloaded with distinct patterns.
  - Response: rd_en high T+1..T+4 with rd_addr_a 0..3 and rd_addr_b 0x100..0x103; o_valid T+3..T+6 with matching data; o_last only at T+6; o_done at T+12.
- Pause:
  - Stimulus: cmd_len=8 with i_pause high for 3 cycles starting after the 2nd read.
  - Response: exactly 8 beats in address order with a 3-cycle gap; no duplicates; o_done 6 cycles after o_last.
- Zero length:
  - Stimulus: cmd_len=0.
  - Response: no rd_en and no o_valid; o_done at T+1; cmd_ready stays 1.
- Address wrap:
  - Stimulus: cmd_addr_a=0x3FE, cmd_len=4.
  - Response: rd_addr_a sequence 0x3FE, 0x3FF, 0x000, 0x001.
- Reset mid-operation:
  - Stimulus: assert rst for 1 cycle while 2 reads are in flight.
  - Response: o_valid=0 the cycle after reset and stays 0; no o_done; cmd_ready=1; a following command runs normally.
- Back-to-back with end-to-end check:
  - Stimulus: connect dpe_vector_feeder to the engine; offer a second command during busy.
  - Response: cmd_ready=0 until after o_done; the second command is accepted in the cycle after o_done; engine results equal the reference dot products per chunk.
